// File: rtl/ext_int_controller.sv
// ext_int_controller: latches peripheral interrupts as pending, masks and prioritises them,
// and drives the core's EIC_I_Req/EIC_I_Id/EIC_I_Ack handshake.
// Ports: Sys_Clock/Sys_Reset   clock, synchronous active-high reset
//        Irq_Src               interrupt source lines
//        IO_EnR/IO_EnW         IO read/write strobes
//        IO_Address/IO_DataW   IO word address and write data
//        IO_DataR              IO read data (0 when not selected for read)
//        EIC_I_Req/EIC_I_Id    registered request and source index to the core
//        EIC_I_Ack             core acknowledge
module ext_int_controller #(
    parameter int          NUM_SRC   = 8,
    parameter int          ID_WIDTH  = 3,
    parameter logic [29:0] BASE_ADDR = 30'h0000100
) (
    input  logic                Sys_Clock,
    input  logic                Sys_Reset,
    input  logic [NUM_SRC-1:0]  Irq_Src,
    input  logic                IO_EnR,
    input  logic                IO_EnW,
    input  logic [29:0]         IO_Address,
    input  logic [31:0]         IO_DataW,
    output logic [31:0]         IO_DataR,
    output logic                EIC_I_Req,
    output logic [ID_WIDTH-1:0] EIC_I_Id,
    input  logic                EIC_I_Ack
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state;
    logic [NUM_SRC-1:0] pend, mask, edg, prev, active, set_v, clr_v, wdat;
    logic [29:0] off;
    logic sel, wr, ack_fire, unused_data;
    logic [ID_WIDTH-1:0] win;
    logic [31:0] status;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare decodes the window
    assign off = IO_Address - BASE_ADDR;
    assign sel = off < 30'd8;
    assign wr = IO_EnW & sel;
    assign wdat = IO_DataW[NUM_SRC-1:0];
    assign unused_data = ^IO_DataW;
    assign active = pend & mask;
    assign ack_fire = (state == REQ) & EIC_I_Ack;
    // Edge sources set only on a rising edge, level sources every cycle they are high
    assign set_v = (Irq_Src & ~(edg & prev)) | ((wr && off[2:0] == 3'd4) ? wdat : '0);
    assign clr_v = ((wr && off[2:0] == 3'd0) ? wdat : '0) | (ack_fire ? NUM_SRC'(1) << EIC_I_Id : '0);

    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (active[i]) win = ID_WIDTH'(i);
    end

    always_comb begin
        status = '0;
        status[ID_WIDTH-1:0] = EIC_I_Id;
        status[31] = state != IDLE;
    end

    assign IO_DataR = !(IO_EnR && sel) ? '0 :
                      off[2:0] == 3'd0 ? 32'(pend) :
                      off[2:0] == 3'd1 ? 32'(mask) :
                      off[2:0] == 3'd2 ? 32'(edg) :
                      off[2:0] == 3'd3 ? status : '0;

    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            pend <= '0;
            mask <= '0;
            edg <= '0;
            prev <= '0;
            state <= IDLE;
            EIC_I_Req <= 1'b0;
            EIC_I_Id <= '0;
        end else begin
            prev <= Irq_Src;
            // Set wins over clear, so a level source still high survives its own ack
            pend <= (pend & ~clr_v) | set_v;
            if (wr && off[2:0] == 3'd1) mask <= wdat;
            if (wr && off[2:0] == 3'd2) edg <= wdat;
            case (state)
                IDLE: if (|active) begin
                    state <= REQ;
                    EIC_I_Req <= 1'b1;
                    EIC_I_Id <= win;
                end
                REQ: if (EIC_I_Ack) begin
                    state <= GAP;
                    EIC_I_Req <= 1'b0;
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ext_int_controller.md
# ext_int_controller

External interrupt controller on the Kabeta IO bus. Collects up to `NUM_SRC` peripheral interrupt lines, latches them as pending, applies software masks and fixed priority, and drives the core's `EIC_I_Req`/`EIC_I_Id`/`EIC_I_Ack` handshake as its requester. Its mask, edge and pending registers are memory-mapped, so it is also a responder on the core's IO bus. It sits beside the core in the system chip and replaces the tied-off `EIC_I_Req`/`EIC_I_Id` inputs.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..32; source 0 has highest priority.
- `ID_WIDTH`, 3: width of `EIC_I_Id`; must satisfy 2^ID_WIDTH >= NUM_SRC.
- `BASE_ADDR`, 30'h0000100: word address of register 0; block decodes BASE_ADDR..BASE_ADDR+7.
- `Sys_Clock`  in  1  system clock; all logic on rising edge.
- `Sys_Reset`  in  1  reset; synchronous, active-high.
- `Irq_Src`  in  NUM_SRC  interrupt lines, synchronous to Sys_Clock.
- `IO_EnR`  in  1  IO read strobe.
- `IO_EnW`  in  1  IO write strobe.
- `IO_Address`  in  30  IO word address.
- `IO_DataW`  in  32  IO write data.
- `IO_DataR`  out  32  IO read data; 0 when not selected for read.
- `EIC_I_Req`  out  1  interrupt request to core.
- `EIC_I_Id`  out  ID_WIDTH  index of requested source.
- `EIC_I_Ack`  in  1  core acknowledge.

## Operation
- Registers, word offset from BASE_ADDR; bits above NUM_SRC-1 read 0 and ignore writes:
  - 0 PEND: R; write-1-to-clear.
  - 1 MASK: R/W; 1 = source enabled. Reset 0.
  - 2 EDGE: R/W; 1 = rising-edge triggered, 0 = level. Reset 0.
  - 3 STATUS: R; bit31 = request outstanding (FSM not IDLE), bits[ID_WIDTH-1:0] = latched Id.
  - 4 SWSET: W; write-1 sets PEND bits. Reads 0.
  - 5..7: reserved; read 0, writes ignored.
- `Prev` register holds Irq_Src from the previous cycle.
- PEND[i] set when: EDGE[i] & Irq_Src[i] & ~Prev[i], or ~EDGE[i] & Irq_Src[i], or SWSET write bit i.
- PEND[i] cleared when: PEND write bit i = 1, or ack of Id i.
- When a set and a clear of the same bit happen in one cycle, set wins.
- A level source still high re-pends on the cycle after its clear.
- Active = PEND & MASK. Winner = lowest set index.
- FSM:
  - IDLE: if Active != 0, latch Id = winner, Req <= 1, go REQ.
  - REQ: Req and Id held stable. Sampled Ack = 1 clears PEND[Id], Req <= 0, go GAP.
  - GAP: one cycle with Req = 0, then IDLE.
- No withdrawal. Masking or clearing the pending source during REQ does not drop Req or change Id. A higher-priority arrival during REQ waits.
- Ack sampled in IDLE or GAP is ignored.
- IO access:
  - Selected when IO_Address is in BASE_ADDR..BASE_ADDR+7.
  - IO_DataR is combinational from current register values while IO_EnR is high and the block is selected.
  - Writes take effect at the clock edge.
  - IO_EnR and IO_EnW together: write performed and read data driven (pre-write values).

## Timing
- Reset: at a Sys_Clock edge with Sys_Reset = 1, all of the following become 0: PEND, MASK, EDGE, Prev, Id, Req. FSM goes to IDLE; IO_DataR is 0.
- Reset mid-request: Req drops after the reset edge; no ack is required.
- Source latency, enabled source, Irq_Src rising before edge k:
  - PEND set after edge k.
  - EIC_I_Req = 1 after edge k+1 (2 cycles).
- SWSET written at edge k: Req after edge k+1.
- Ack high at edge m:
  - Req = 0 and PEND[Id] cleared after edge m.
  - Earliest next Req after edge m+2.
- Outputs are registered; EIC_I_Req and EIC_I_Id have no combinational path from inputs.
- IO read: zero-wait-state.

## Test plan
- Reset, then read offsets 0..4: all read 0; EIC_I_Req = 0 and EIC_I_Id = 0 throughout.
- MASK=0xFF, EDGE=0x00; pulse Irq_Src[5] high for 1 cycle at edge k.
  - Req=1, Id=5 after edge k+1; hold Ack low 10 cycles: Req and Id stay stable.
  - Ack at edge m: Req=0 after edge m; PEND reads 0x00.
- MASK=0xFF; pend sources 6 and 2 in the same cycle.
  - Id=2 first. After its ack and the GAP cycle, Id=6; second Req rises exactly 2 edges after the first ack.
- EDGE=0x01, MASK=0x01; hold Irq_Src[0] high 20 cycles.
  - Exactly one request.
  - Same source in level mode: re-requests after every GAP while high.
- MASK=0x00; SWSET write 0x08.
  - PEND=0x08, no Req.
  - Write MASK=0x08: Req, Id=3 two edges after the MASK write.
  - PEND write 0x08 in the same cycle as an edge on source 3 (EDGE=0x08): PEND bit 3 stays 1.
- During REQ (Id=4):
  - Assert Sys_Reset for 1 cycle: Req=0 and all registers 0 after the reset edge.
  - Without reset, clearing MASK: Req stays 1 until Ack.
